// File: rtl/sh7604_ibus_arb_pkg.sv
// Shared types for the SH7604 internal-bus arbiter.
// Optional fairness token: build with SH7604_IBUS_ARB_FAIR_EN defined.
package sh7604_ibus_arb_pkg;

  localparam int unsigned IBUS_CF_BURST_LEN = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StOwn    = 2'd1,
    StBurst  = 2'd2,
    StLocked = 2'd3
  } IbusArbState_t;

  typedef enum logic [1:0] {
    MstNone = 2'd0,
    MstCpu  = 2'd1,
    MstCf   = 2'd2,
    MstDma  = 2'd3
  } IbusMst_t;

endpackage

// File: rtl/sh7604_ibus_arb_prio.sv
// Fixed-priority winner select (DMA > CF > CPU) with an optional one-shot CPU fairness token.
// The token is only armed when SH7604_IBUS_ARB_FAIR_EN is defined.
module sh7604_ibus_arb_prio
  import sh7604_ibus_arb_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_ce_r,
  input  logic     i_cpu_req,
  input  logic     i_cf_req,
  input  logic     i_dma_req,
  input  logic     i_dma_done,
  input  logic     i_take,
  output IbusMst_t o_win
);

`ifdef SH7604_IBUS_ARB_FAIR_EN
  localparam bit FairEn = 1'b1;
`else
  localparam bit FairEn = 1'b0;
`endif

  logic r_tok;

  always_comb begin
    o_win = MstNone;
    if (FairEn && r_tok && i_cpu_req) begin
      o_win = MstCpu;
    end else if (i_dma_req) begin
      o_win = MstDma;
    end else if (i_cf_req) begin
      o_win = MstCf;
    end else if (i_cpu_req) begin
      o_win = MstCpu;
    end
  end

  // Token is spent by the first CPU grant after a DMA beat that left the CPU waiting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tok <= 1'b0;
    end else if (i_ce_r) begin
      if (i_take && (o_win == MstCpu)) begin
        r_tok <= 1'b0;
      end else if (FairEn && i_dma_done && i_cpu_req) begin
        r_tok <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sh7604_ibus_arb.sv
// SH7604 IBUS arbiter: merges CPU, cache line-fill and DMAC onto the bus state controller.
// Fairness option selected by SH7604_IBUS_ARB_FAIR_EN (see sh7604_ibus_arb_prio).
module sh7604_ibus_arb
  import sh7604_ibus_arb_pkg::*;
#(
  parameter int unsigned BURST_LEN = IBUS_CF_BURST_LEN,
  parameter bit          PARK_CPU  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ce_r,
  input  logic        i_ce_f,
  input  logic [31:0] i_cpu_a,
  input  logic [31:0] i_cpu_di,
  input  logic [3:0]  i_cpu_ba,
  input  logic        i_cpu_we,
  input  logic        i_cpu_req,
  input  logic        i_cpu_lock,
  output logic        o_cpu_busy,
  input  logic [31:0] i_cf_a,
  input  logic        i_cf_req,
  output logic        o_cf_busy,
  input  logic [31:0] i_dma_a,
  input  logic [31:0] i_dma_di,
  input  logic [3:0]  i_dma_ba,
  input  logic        i_dma_we,
  input  logic        i_dma_req,
  output logic        o_dma_busy,
  output logic [31:0] o_mst_do,
  output logic [31:0] o_s_a,
  output logic [31:0] o_s_di,
  output logic [3:0]  o_s_ba,
  output logic        o_s_we,
  output logic        o_s_req,
  output logic        o_s_burst,
  output logic        o_s_lock,
  input  logic [31:0] i_s_do,
  input  logic        i_s_busy,
  output logic [1:0]  o_gnt
);

  localparam int unsigned CW      = $clog2(BURST_LEN);
  localparam IbusMst_t    IdleGnt = PARK_CPU ? MstCpu : MstNone;

  IbusArbState_t   r_state, w_state_nxt;
  IbusMst_t        r_gnt, w_gnt_nxt, w_win, w_mst, w_own;
  logic            r_pend, w_pend_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt, w_cnt;
  logic [CW-1:0]   r_beats, w_beats_nxt;
  logic [31:2+CW]  r_cf_hi, w_cf_hi_nxt, w_cf_hi;
  logic            w_idle, w_done, w_own_busy;
  logic            w_unused;

  assign w_idle  = (r_state == StIdle);
  assign w_own   = w_idle ? MstNone : r_gnt;
  // While idle the winner drives the bus combinationally so the request is forwarded this CE_R.
  assign w_mst   = w_idle ? w_win : r_gnt;
  assign w_cnt   = w_idle ? i_cf_a[1+CW:2] : r_cnt;
  assign w_cf_hi = w_idle ? i_cf_a[31:2+CW] : r_cf_hi;
  assign w_done  = o_s_req & ~i_s_busy & r_pend;

  assign w_unused = ^{i_ce_f, i_cf_a[1:0]};

  sh7604_ibus_arb_prio u_prio (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ce_r     (i_ce_r),
    .i_cpu_req  (i_cpu_req),
    .i_cf_req   (i_cf_req),
    .i_dma_req  (i_dma_req),
    .i_dma_done (w_done && (w_own == MstDma)),
    .i_take     (w_idle),
    .o_win      (w_win)
  );

  always_comb begin
    o_s_a     = '0;
    o_s_di    = '0;
    o_s_ba    = '0;
    o_s_we    = 1'b0;
    o_s_req   = 1'b0;
    o_s_burst = 1'b0;
    o_s_lock  = 1'b0;
    if (!i_rst) begin
      unique case (w_mst)
        MstCpu: begin
          o_s_a    = i_cpu_a;
          o_s_di   = i_cpu_di;
          o_s_ba   = i_cpu_ba;
          o_s_we   = i_cpu_we;
          o_s_req  = i_cpu_req | r_pend;
          o_s_lock = i_cpu_lock;
        end
        MstCf: begin
          o_s_a     = {w_cf_hi, w_cnt, 2'b00};
          o_s_ba    = 4'hF;
          o_s_req   = (r_state == StBurst) | i_cf_req;
          o_s_burst = 1'b1;
        end
        MstDma: begin
          o_s_a   = i_dma_a;
          o_s_di  = i_dma_di;
          o_s_ba  = i_dma_ba;
          o_s_we  = i_dma_we;
          o_s_req = i_dma_req | r_pend;
        end
        default: ;
      endcase
    end
  end

  assign w_own_busy = i_s_busy | ~r_pend;
  assign o_cpu_busy = (w_own == MstCpu) ? w_own_busy : i_cpu_req;
  assign o_cf_busy  = (w_own == MstCf) ? (i_cf_req & w_own_busy) : i_cf_req;
  assign o_dma_busy = (w_own == MstDma) ? w_own_busy : i_dma_req;
  assign o_mst_do   = i_s_do;
  assign o_gnt      = r_gnt;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_pend_nxt  = r_pend;
    w_cnt_nxt   = r_cnt;
    w_beats_nxt = r_beats;
    w_cf_hi_nxt = r_cf_hi;
    unique case (r_state)
      StIdle: begin
        if (w_win != MstNone) begin
          w_gnt_nxt   = w_win;
          w_pend_nxt  = 1'b1;
          w_cnt_nxt   = w_cnt;
          w_beats_nxt = '0;
          w_cf_hi_nxt = w_cf_hi;
          if (w_win == MstCf) begin
            w_state_nxt = StBurst;
          end else if ((w_win == MstCpu) && i_cpu_lock) begin
            w_state_nxt = StLocked;
          end else begin
            w_state_nxt = StOwn;
          end
        end
      end
      StOwn: begin
        if (w_done) begin
          w_state_nxt = StIdle;
          w_gnt_nxt   = IdleGnt;
          w_pend_nxt  = 1'b0;
        end
      end
      StBurst: begin
        if (w_done) begin
          w_pend_nxt  = 1'b0;
          w_cnt_nxt   = r_cnt + 1'b1;
          w_beats_nxt = r_beats + 1'b1;
          if (r_beats == CW'(BURST_LEN - 1)) begin
            w_state_nxt = StIdle;
            w_gnt_nxt   = IdleGnt;
          end
        end else if (!r_pend) begin
          w_pend_nxt = 1'b1;
        end
      end
      StLocked: begin
        if (w_done) begin
          w_pend_nxt = 1'b0;
          if (!i_cpu_lock) begin
            w_state_nxt = StIdle;
            w_gnt_nxt   = IdleGnt;
          end
        end else if (!r_pend && o_s_req) begin
          w_pend_nxt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_gnt   <= IdleGnt;
      r_pend  <= 1'b0;
      r_cnt   <= '0;
      r_beats <= '0;
      r_cf_hi <= '0;
    end else if (i_ce_r) begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_pend  <= w_pend_nxt;
      r_cnt   <= w_cnt_nxt;
      r_beats <= w_beats_nxt;
      r_cf_hi <= w_cf_hi_nxt;
    end
  end

endmodule

// File: tb/tb_sh7604_ibus_arb.sv
// Directed bench for sh7604_ibus_arb; expectations follow SH7604_IBUS_ARB_FAIR_EN when defined.
module tb_sh7604_ibus_arb;

  logic        clk = 1'b0;
  logic        rst, ce_r, ce_f;
  logic [31:0] cpu_a, cpu_di, cf_a, dma_a, dma_di, s_do;
  logic [3:0]  cpu_ba, dma_ba;
  logic        cpu_we, cpu_req, cpu_lock, cf_req, dma_we, dma_req, s_busy;
  logic        cpu_busy, cf_busy, dma_busy;
  logic [31:0] mst_do, s_a, s_di;
  logic [3:0]  s_ba;
  logic        s_we, s_req, s_burst, s_lock;
  logic [1:0]  gnt;

  int          n_vec = 0;
  int          n_err = 0;
  int          dn, cn, nc;
  logic [19:0] mask, exp_mask;
  logic [31:0] cf_exp [4];

  always #5 clk = ~clk;

  sh7604_ibus_arb dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ce_r     (ce_r),
    .i_ce_f     (ce_f),
    .i_cpu_a    (cpu_a),
    .i_cpu_di   (cpu_di),
    .i_cpu_ba   (cpu_ba),
    .i_cpu_we   (cpu_we),
    .i_cpu_req  (cpu_req),
    .i_cpu_lock (cpu_lock),
    .o_cpu_busy (cpu_busy),
    .i_cf_a     (cf_a),
    .i_cf_req   (cf_req),
    .o_cf_busy  (cf_busy),
    .i_dma_a    (dma_a),
    .i_dma_di   (dma_di),
    .i_dma_ba   (dma_ba),
    .i_dma_we   (dma_we),
    .i_dma_req  (dma_req),
    .o_dma_busy (dma_busy),
    .o_mst_do   (mst_do),
    .o_s_a      (s_a),
    .o_s_di     (s_di),
    .o_s_ba     (s_ba),
    .o_s_we     (s_we),
    .o_s_req    (s_req),
    .o_s_burst  (s_burst),
    .o_s_lock   (s_lock),
    .i_s_do     (s_do),
    .i_s_busy   (s_busy),
    .o_gnt      (gnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ce_r = 1'b1; ce_f = 1'b0;
    cpu_a = '0; cpu_di = '0; cpu_ba = 4'hF; cpu_we = 1'b0; cpu_req = 1'b0; cpu_lock = 1'b0;
    cf_a = '0; cf_req = 1'b0;
    dma_a = '0; dma_di = '0; dma_ba = 4'hF; dma_we = 1'b0; dma_req = 1'b0;
    s_busy = 1'b1; s_do = '0;
    cf_exp[0] = 32'h0600_002C; cf_exp[1] = 32'h0600_0020;
    cf_exp[2] = 32'h0600_0024; cf_exp[3] = 32'h0600_0028;
    repeat (3) cyc();
    rst = 1'b0; #1;
    check_eq("rst_gnt", gnt, 32'd1);
    check_eq("rst_sreq", s_req, 32'd0);
    check_eq("rst_sa", s_a, 32'd0);
    check_eq("rst_cpu_busy", cpu_busy, 32'd0);

    // CPU read with three busy CE_R
    cyc(); cpu_req = 1'b1; cpu_a = 32'h0600_0010; s_busy = 1'b1; #1;
    check_eq("cpu_sreq", s_req, 32'd1);
    check_eq("cpu_sa", s_a, 32'h0600_0010);
    check_eq("cpu_busy_fwd", cpu_busy, 32'd1);
    repeat (2) begin
      cyc(); #1;
      check_eq("cpu_busy_wait", cpu_busy, 32'd1);
    end
    cyc(); s_busy = 1'b0; s_do = 32'hCAFE_F00D; #1;
    check_eq("cpu_busy_done", cpu_busy, 32'd0);
    check_eq("cpu_mst_do", mst_do, 32'hCAFE_F00D);
    check_eq("cpu_sa_hold", s_a, 32'h0600_0010);
    cyc(); cpu_req = 1'b0; s_busy = 1'b1; #1;
    check_eq("cpu_sreq_off", s_req, 32'd0);

    // Cache line-fill burst with critical-word-first wrap
    cf_a = 32'h0600_002C;
    for (int b = 0; b < 4; b++) begin
      cyc(); cf_req = 1'b1; s_busy = 1'b1; #1;
      check_eq($sformatf("cf_sa%0d", b), s_a, cf_exp[b]);
      check_eq($sformatf("cf_burst%0d", b), s_burst, 32'd1);
      check_eq($sformatf("cf_sreq%0d", b), s_req, 32'd1);
      check_eq($sformatf("cf_ba%0d", b), s_ba, 32'hF);
      cyc(); s_busy = 1'b0; #1;
      check_eq($sformatf("cf_busy%0d", b), cf_busy, 32'd0);
      check_eq($sformatf("cf_gnt%0d", b), gnt, 32'd2);
    end
    cyc(); cf_req = 1'b0; s_busy = 1'b1; #1;
    check_eq("cf_end_sreq", s_req, 32'd0);
    check_eq("cf_end_burst", s_burst, 32'd0);
    check_eq("cf_end_gnt", gnt, 32'd1);

    // DMA and CPU tie: DMA first, then CPU
    cyc(); dma_req = 1'b1; dma_a = 32'h0000_1000; dma_di = 32'h1234_5678; dma_we = 1'b1;
    cpu_req = 1'b1; cpu_a = 32'h0600_0040; cpu_we = 1'b0; s_busy = 1'b1; #1;
    check_eq("tie_sa", s_a, 32'h0000_1000);
    check_eq("tie_swe", s_we, 32'd1);
    check_eq("tie_cpu_busy", cpu_busy, 32'd1);
    cyc(); #1;
    check_eq("tie_gnt", gnt, 32'd3);
    check_eq("tie_sdi", s_di, 32'h1234_5678);
    cyc(); s_busy = 1'b0; #1;
    check_eq("tie_dma_done", dma_busy, 32'd0);
    check_eq("tie_cpu_wait", cpu_busy, 32'd1);
    cyc(); dma_req = 1'b0; dma_we = 1'b0; s_busy = 1'b1; #1;
    check_eq("tie_cpu_sa", s_a, 32'h0600_0040);
    cyc(); s_busy = 1'b0; #1;
    check_eq("tie_cpu_gnt", gnt, 32'd1);
    check_eq("tie_cpu_done", cpu_busy, 32'd0);
    cyc(); cpu_req = 1'b0; s_busy = 1'b1;

    // Locked read-modify-write holds off DMA
    cyc(); cpu_req = 1'b1; cpu_lock = 1'b1; cpu_a = 32'h0600_0100; cpu_we = 1'b0; #1;
    check_eq("lock_slock", s_lock, 32'd1);
    cyc(); s_busy = 1'b0; #1;
    check_eq("lock_rd_done", cpu_busy, 32'd0);
    cyc(); cpu_req = 1'b0; dma_req = 1'b1; dma_a = 32'h0000_2000; s_busy = 1'b1; #1;
    check_eq("lock_gap_sreq", s_req, 32'd0);
    check_eq("lock_gap_dma_busy", dma_busy, 32'd1);
    check_eq("lock_gap_gnt", gnt, 32'd1);
    cyc(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_lock = 1'b0; cpu_di = 32'h0000_00A5; #1;
    check_eq("lock_wr_sa", s_a, 32'h0600_0100);
    check_eq("lock_wr_swe", s_we, 32'd1);
    check_eq("lock_wr_slock", s_lock, 32'd0);
    cyc(); s_busy = 1'b0; #1;
    check_eq("lock_dma_wait", dma_busy, 32'd1);
    check_eq("lock_wr_done", cpu_busy, 32'd0);
    cyc(); cpu_req = 1'b0; cpu_we = 1'b0; s_busy = 1'b1; #1;
    check_eq("lock_dma_sa", s_a, 32'h0000_2000);
    cyc(); s_busy = 1'b0; #1;
    check_eq("lock_dma_gnt", gnt, 32'd3);
    cyc(); dma_req = 1'b0; s_busy = 1'b1;

    // DMA held for 10 beats against a waiting CPU
    dn = 0; cn = 0; nc = 0; mask = '0;
    for (int c = 0; c < 200 && nc < 20; c++) begin
      cyc(); s_busy = 1'b0; dma_req = (dn < 10); cpu_req = 1'b1; #1;
      if (dma_req && !dma_busy) begin
        dn++; nc++;
      end else if (cpu_req && !cpu_busy) begin
        mask[nc] = 1'b1; cn++; nc++;
      end
    end
`ifdef SH7604_IBUS_ARB_FAIR_EN
    exp_mask = 20'hAAAAA;
`else
    exp_mask = 20'hFFC00;
`endif
    check_eq("fair_beats", nc, 32'd20);
    check_eq("fair_dma_beats", dn, 32'd10);
    check_eq("fair_order", mask, exp_mask);
    cyc(); cpu_req = 1'b0; dma_req = 1'b0; s_busy = 1'b1;

    // CF drops its request mid-burst, then reset during beat 2
    cyc(); cf_req = 1'b1; cf_a = 32'h0600_0080; #1;
    check_eq("rb_sa0", s_a, 32'h0600_0080);
    cyc(); s_busy = 1'b0;
    cyc(); cf_req = 1'b0; s_busy = 1'b1; #1;
    check_eq("cf_drop_sreq", s_req, 32'd1);
    check_eq("cf_drop_sa", s_a, 32'h0600_0084);
    check_eq("cf_drop_busy", cf_busy, 32'd0);
    cyc(); s_busy = 1'b0; #1;
    check_eq("cf_drop_done", cf_busy, 32'd0);
    cyc(); s_busy = 1'b1; rst = 1'b1; #1;
    check_eq("rst_mid_sreq", s_req, 32'd0);
    check_eq("rst_mid_sa", s_a, 32'd0);
    cyc(); rst = 1'b0; #1;
    check_eq("rst_after_sreq", s_req, 32'd0);
    check_eq("rst_after_gnt", gnt, 32'd1);
    check_eq("rst_after_burst", s_burst, 32'd0);
    cyc(); cpu_req = 1'b1; cpu_a = 32'h0600_0200; s_busy = 1'b0; #1;
    check_eq("rst_cpu_fwd_busy", cpu_busy, 32'd1);
    check_eq("rst_cpu_sa", s_a, 32'h0600_0200);
    cyc(); #1;
    check_eq("rst_cpu_done", cpu_busy, 32'd0);
    cyc(); cpu_req = 1'b0; s_busy = 1'b1;

    // No state change without CE_R
    cyc(); ce_r = 1'b0; dma_req = 1'b1; dma_a = 32'h0000_3000;
    cyc(); #1;
    check_eq("ce_hold_gnt", gnt, 32'd1);
    cyc(); ce_r = 1'b1; #1;
    check_eq("ce_dma_busy", dma_busy, 32'd1);
    cyc(); #1;
    check_eq("ce_gnt", gnt, 32'd3);
    cyc(); s_busy = 1'b0;
    cyc(); dma_req = 1'b0; s_busy = 1'b1; #1;
    check_eq("ce_end_sreq", s_req, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
